// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: multi-cycle shifter/rotator. Moves the operand at most
// STEP bit positions per RUN cycle, then presents a registered result
// together with a one-cycle done pulse.
// Optional feature macro: SHIFT_CARRY_EN adds the cout port (last bit shifted out).
//
// state | meaning
// IDLE  | waiting for start; operands are latched when start is seen
// RUN   | working register moves by min(STEP, rem) each cycle
// DONE  | result/cout valid, done pulses for this single cycle
module shift_rotate_unit #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] amt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef SHIFT_CARRY_EN
  ,
  output logic              cout
`endif
);

  localparam int AW = $clog2(DATA_W);
  // STEP may equal DATA_W, which needs one more bit than a shift amount
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [AW-1:0]       rem_q, rem_d;
  logic [AW-1:0]       amt_k;
  logic [AW-1:0]       step_s;
  logic [AW-1:0]       inv_s;
  logic [DATA_W-1:0]   shifted;
  logic                op_valid;
  logic                unused_amt;

  assign amt_k      = amt[AW-1:0];
  assign unused_amt = ^amt[DATA_W-1:AW];
  assign op_valid   = (opcode == OP_SHR) || (opcode == OP_SHRA) || (opcode == OP_SHL) ||
                      (opcode == OP_ROR) || (opcode == OP_ROL);

  // Per-cycle move distance; inv_s is DATA_W - step_s modulo DATA_W
  always_comb begin
    step_s = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[AW-1:0];
    inv_s  = -step_s;
  end

  // One step of the latched operation applied to the working register
  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SHR:  shifted = work_q >> step_s;
      OP_SHRA: shifted = $signed(work_q) >>> step_s;
      OP_SHL:  shifted = work_q << step_s;
      OP_ROR:  shifted = (work_q >> step_s) | (work_q << inv_s);
      OP_ROL:  shifted = (work_q << step_s) | (work_q >> inv_s);
      default: shifted = work_q;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ((amt_k == '0) || !op_valid) ? DONE : RUN;
      RUN:  if (rem_q == step_s) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next values; result only changes on the way into DONE
  always_comb begin
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        op_d = opcode;
        if ((amt_k == '0) || !op_valid) begin
          result_d = a;
          rem_d    = '0;
        end else begin
          work_d = a;
          rem_d  = amt_k;
        end
      end
      RUN: begin
        work_d = shifted;
        rem_d  = rem_q - step_s;
        if (rem_q == step_s) result_d = shifted;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q     <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef SHIFT_CARRY_EN
  logic step_carry;
  logic cout_q, cout_d;

  // Bit that leaves the register on this step: MSB side for left moves, LSB side otherwise
  always_comb begin
    case (op_q)
      OP_SHL, OP_ROL: step_carry = work_q[inv_s];
      default:        step_carry = work_q[step_s - 1'b1];
    endcase
  end

  // Carry tracks result: cleared on zero-length/invalid ops, last step's bit otherwise
  always_comb begin
    cout_d = cout_q;
    if ((state_q == IDLE) && start && ((amt_k == '0) || !op_valid)) cout_d = 1'b0;
    else if ((state_q == RUN) && (rem_q == step_s))                 cout_d = step_carry;
  end

  // Carry register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) cout_q <= 1'b0;
    else        cout_q <= cout_d;
  end

  assign cout = cout_q;
`endif

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width, power of two, 8..64.
REQ-002 Parameter STEP, default 4: max bit positions moved per RUN cycle, power of two, 1..DATA_W.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 opcode  input  5  00100 SHR, 00101 SHRA, 00110 SHL, 00111 ROR, 01000 ROL; any other code is a pass-through.
REQ-007 a  input  DATA_W  operand to be shifted.
REQ-008 amt  input  DATA_W  shift amount; only the low log2(DATA_W) bits are used.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  DATA_W  registered result.
REQ-012 cout  output  1  last bit shifted or rotated out; present only with SHIFT_CARRY_EN.

Function
REQ-013 States: IDLE, RUN, DONE; the module SHALL use no other states.
REQ-014 IDLE with start=1: latch a, opcode, k=amt[log2(DATA_W)-1:0]; go to DONE if k==0 or the opcode is invalid, else go to RUN with rem=k.
REQ-015 RUN, each edge: s=min(STEP,rem); apply the latched op by s to the working register; rem-=s; go to DONE when rem reaches 0.
REQ-016 SHR fills with 0 from MSB; SHRA fills with the sign bit; SHL fills with 0 from LSB; ROR/ROL wrap modulo DATA_W.
REQ-017 Latency: done high in the cycle following edge 1+ceil(k/STEP), counting from the start-sampling edge (k=0: edge 1).
REQ-018 DONE: done=1 for exactly one cycle; the next state is unconditionally IDLE.
REQ-019 result SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-020 start in RUN or DONE SHALL be ignored, with no queueing; opcode/a/amt changes after acceptance SHALL have no effect.
REQ-021 Invalid opcode: result=a, with a latency of 1 (same as k=0).
REQ-022 Back-to-back: start held high re-accepts on the IDLE cycle following DONE.

Reset
REQ-023 clear low SHALL force IDLE, busy=0, done=0, result=0, cout=0 and rem=0 immediately, regardless of clock.
REQ-024 A reset mid-RUN SHALL abandon the operation with no done pulse; operation resumes from IDLE after clear rises.

Configuration
REQ-025 Macro SHIFT_CARRY_EN defined: cout port exists.
  - SHL/ROL: cout = last bit leaving the MSB.
  - SHR/SHRA/ROR: cout = last bit leaving the LSB.
  - k==0 or invalid opcode: cout=0.
  - cout updates with result.
REQ-026 SHIFT_CARRY_EN undefined: cout port and its logic SHALL be absent; all other behaviour is identical.

Verification (DATA_W=32, STEP=4)
REQ-027 ROR a=0xF0000022, amt=4 -> result 0x2F000002, done 2 cycles after start, busy high for 2 cycles.
REQ-028 ROL a=0xF0000022, amt=0x24 (masked to 4) -> result 0x0000022F, latency 2.
REQ-029 SHRA a=0x80000000, amt=9 -> result 0xFFC00000, latency 4; start pulsed during RUN is ignored (exactly one done).
REQ-030 SHL a=0x12345678, amt=0 -> result 0x12345678 at latency 1; opcode 11111 -> result=a at latency 1.
REQ-031 ROR amt=31 started, clear pulsed low at RUN cycle 3 -> busy=0, result=0, no done; a following ROR 0x1 by 1 -> 0x80000000.
REQ-032 With SHIFT_CARRY_EN, SHL a=0x80000001, amt=1 -> result 0x00000002, cout=1; SHR a=0x2, amt=1 -> result 0x1, cout=0.
